// File: rtl/mem_ctrl.sv
// Byte-bus memory controller: arbitrates IF/LS and splits each access into 8-bit bus cycles.
// Reads finish in n+2 cycles and writes in n+1, plus stalls; rdy_in low freezes the whole block.
module mem_ctrl #(
  parameter bit LS_PRIORITY = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        flush,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]  state;
  logic [31:0] addr, wdata, acc;
  logic [2:0]  n, k;
  logic        owner_ls, wr_q;

  logic        if_ok, ls_ok, grant_ls, grant_if, stall;
  logic [31:0] grant_addr, acc_next;
  logic [2:0]  grant_n, k_inc;
  logic [5:0]  cap_sh;
  logic [7:0]  wbyte;

  // A raised done output masks its own requester, so a held req is not re-served.
  assign if_ok      = if_req && !if_done && !flush;
  assign ls_ok      = ls_req && !ls_done;
  assign grant_ls   = ls_ok && (LS_PRIORITY || !if_ok);
  assign grant_if   = if_ok && !grant_ls;
  assign grant_addr = grant_ls ? ls_addr : if_addr;

  always_comb begin
    grant_n = 3'd4;
    if (grant_ls) begin
      case (ls_size)
        2'b00:   grant_n = 3'd1;
        2'b01:   grant_n = 3'd2;
        default: grant_n = 3'd4;
      endcase
    end
  end

  // In READ, k counts cycles: byte k-1 arrives on mem_din while k runs 1..n.
  assign k_inc    = k + 3'd1;
  assign cap_sh   = {k - 3'd1, 3'b000};
  assign acc_next = acc | ({24'd0, mem_din} << cap_sh);
  assign wbyte    = 8'(wdata >> {k_inc, 3'b000});

  // UART stall has to act in the same cycle the buffer reports full.
  assign stall  = wr_q && (mem_a[17:16] == 2'b11) && io_buffer_full;
  assign mem_wr = wr_q && rdy_in && !stall;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      addr     <= '0;
      wdata    <= '0;
      acc      <= '0;
      n        <= '0;
      k        <= '0;
      owner_ls <= 1'b0;
      wr_q     <= 1'b0;
      mem_a    <= '0;
      mem_dout <= '0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
    end else if (rdy_in) begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ls || grant_if) begin
            owner_ls <= grant_ls;
            addr     <= grant_addr;
            n        <= grant_n;
            wdata    <= ls_wdata;
            acc      <= '0;
            k        <= '0;
            mem_a    <= grant_addr;
            if (grant_ls && ls_we) begin
              state    <= WRITE;
              mem_dout <= ls_wdata[7:0];
              wr_q     <= 1'b1;
            end else begin
              state    <= READ;
              mem_dout <= '0;
              wr_q     <= 1'b0;
            end
          end
        end
        READ: begin
          if (!owner_ls && flush) begin
            state <= IDLE;
            mem_a <= '0;
          end else begin
            if (k != 3'd0) acc <= acc_next;
            if (k == n) begin
              state <= IDLE;
              if (owner_ls) begin
                ls_done  <= 1'b1;
                ls_rdata <= acc_next;
              end else begin
                if_done <= 1'b1;
                if_data <= acc_next;
              end
            end
            k     <= k_inc;
            mem_a <= (k_inc < n) ? addr + {29'd0, k_inc} : 32'd0;
          end
        end
        WRITE: begin
          if (!stall) begin
            if (k_inc == n) begin
              state    <= IDLE;
              ls_done  <= 1'b1;
              mem_a    <= '0;
              mem_dout <= '0;
              wr_q     <= 1'b0;
            end else begin
              k        <= k_inc;
              mem_a    <= addr + {29'd0, k_inc};
              mem_dout <= wbyte;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus randomized transactions against a byte-memory reference.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, io_buffer_full, if_req, flush, ls_req, ls_we;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a, if_addr, if_data, ls_addr, ls_wdata, ls_rdata;
  logic        mem_wr, if_done, ls_done;
  logic [1:0]  ls_size;

  int cmp = 0;
  int err = 0;

  logic [7:0]  mem     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [39:0] wlog[$];

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .flush(flush),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input int nb);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = ref_rd(a + 32'(i));
    return r;
  endfunction

  // External byte memory: data appears the cycle after its address, held while paused.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      mem_din <= mem_rd(mem_a);
      if (mem_wr) begin
        mem[mem_a] = mem_dout;
        wlog.push_back({mem_a, mem_dout});
      end
    end
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  task automatic test_reset;
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00;
    ls_addr = '0; ls_wdata = '0;
    #3;
    cmp++; if (mem_a !== 32'd0)    begin err++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
    cmp++; if (mem_wr !== 1'b0)    begin err++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
    cmp++; if (mem_dout !== 8'd0)  begin err++; $display("FAIL reset_mem_dout got %h want 0", mem_dout); end
    cmp++; if (if_done !== 1'b0)   begin err++; $display("FAIL reset_if_done got %b want 0", if_done); end
    cmp++; if (ls_done !== 1'b0)   begin err++; $display("FAIL reset_ls_done got %b want 0", ls_done); end
    cmp++; if (if_data !== 32'd0)  begin err++; $display("FAIL reset_if_data got %h want 0", if_data); end
    cmp++; if (ls_rdata !== 32'd0) begin err++; $display("FAIL reset_ls_rdata got %h want 0", ls_rdata); end
    tick; tick;
    rst_in = 1'b0;
    tick; #1;
    cmp++; if (mem_a !== 32'd0 || mem_wr !== 1'b0) begin
      err++; $display("FAIL idle_after_reset mem_a=%h mem_wr=%b want 0/0", mem_a, mem_wr);
    end
  endtask

  task automatic test_word_fetch;
    logic [31:0] exp_a;
    tick;
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h50); preload(32'h103, 8'h00);
    if_addr = 32'h100; if_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick; #1;
      exp_a = (c <= 4) ? 32'h100 + 32'(c - 1) : 32'h0;
      cmp++; if (mem_a !== exp_a) begin err++; $display("FAIL fetch_addr c%0d got %h want %h", c, mem_a, exp_a); end
      cmp++; if (if_done !== (c == 6)) begin err++; $display("FAIL fetch_done c%0d got %b want %b", c, if_done, c == 6); end
      if (c == 6) begin
        cmp++; if (if_data !== 32'h00500513) begin err++; $display("FAIL fetch_data got %h want 00500513", if_data); end
      end
      if (c == 7) if_req = 1'b0;
    end
  endtask

  task automatic test_priority;
    logic [31:0] exp_w;
    tick;
    preload(32'h200, 8'hFF);
    exp_w = exp_read(32'h0, 4);
    if_addr = 32'h0; if_req = 1'b1;
    ls_addr = 32'h200; ls_size = 2'b00; ls_we = 1'b0; ls_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick; #1;
      if (c == 1) begin
        cmp++; if (mem_a !== 32'h200) begin err++; $display("FAIL prio_first_addr got %h want 00000200", mem_a); end
      end
      cmp++; if (ls_done !== (c == 3)) begin err++; $display("FAIL prio_ls_done c%0d got %b want %b", c, ls_done, c == 3); end
      cmp++; if (if_done !== (c == 9)) begin err++; $display("FAIL prio_if_done c%0d got %b want %b", c, if_done, c == 9); end
      if (c == 3) begin
        cmp++; if (ls_rdata !== 32'h000000FF) begin err++; $display("FAIL prio_ls_rdata got %h want 000000ff", ls_rdata); end
        ls_req = 1'b0;
      end
      if (c == 9) begin
        cmp++; if (if_data !== exp_w) begin err++; $display("FAIL prio_if_data got %h want %h", if_data, exp_w); end
        if_req = 1'b0;
      end
    end
  endtask

  task automatic test_half_store;
    logic [31:0] exp_a;
    logic [7:0]  exp_d;
    tick;
    wlog.delete();
    ls_we = 1'b1; ls_size = 2'b01; ls_addr = 32'h1001; ls_wdata = 32'h1234BEEF; ls_req = 1'b1;
    ref_mem[32'h1001] = 8'hEF; ref_mem[32'h1002] = 8'hBE;
    for (int c = 1; c <= 4; c++) begin
      tick; #1;
      exp_a = (c == 1) ? 32'h1001 : (c == 2) ? 32'h1002 : 32'h0;
      exp_d = (c == 1) ? 8'hEF : (c == 2) ? 8'hBE : 8'h00;
      cmp++; if (mem_wr !== (c <= 2)) begin err++; $display("FAIL hstore_wr c%0d got %b want %b", c, mem_wr, c <= 2); end
      cmp++; if (mem_a !== exp_a) begin err++; $display("FAIL hstore_addr c%0d got %h want %h", c, mem_a, exp_a); end
      cmp++; if (mem_dout !== exp_d) begin err++; $display("FAIL hstore_dout c%0d got %h want %h", c, mem_dout, exp_d); end
      cmp++; if (ls_done !== (c == 3)) begin err++; $display("FAIL hstore_done c%0d got %b want %b", c, ls_done, c == 3); end
      if (c == 3) ls_req = 1'b0;
    end
    ls_we = 1'b0;
  endtask

  task automatic test_io_stall;
    tick;
    ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h30000; ls_wdata = 32'h00000041; ls_req = 1'b1;
    ref_mem[32'h30000] = 8'h41;
    for (int c = 1; c <= 6; c++) begin
      tick;
      io_buffer_full = (c >= 1 && c <= 3);
      #1;
      cmp++; if (mem_wr !== (c == 4)) begin err++; $display("FAIL io_wr c%0d got %b want %b", c, mem_wr, c == 4); end
      cmp++; if (ls_done !== (c == 5)) begin err++; $display("FAIL io_done c%0d got %b want %b", c, ls_done, c == 5); end
      if (c <= 4) begin
        cmp++; if (mem_a !== 32'h30000) begin err++; $display("FAIL io_addr c%0d got %h want 00030000", c, mem_a); end
      end
      if (c == 5) ls_req = 1'b0;
    end
    io_buffer_full = 1'b0; ls_we = 1'b0;
  endtask

  task automatic test_flush;
    tick;
    if_addr = 32'h400; if_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick;
      if (c == 2) begin ls_addr = 32'h500; ls_size = 2'b00; ls_we = 1'b0; ls_req = 1'b1; end
      if (c == 3) flush = 1'b1;
      if (c == 4) begin flush = 1'b0; if_req = 1'b0; end
      #1;
      cmp++; if (if_done !== 1'b0) begin err++; $display("FAIL flush_if_done c%0d got %b want 0", c, if_done); end
      if (c <= 3) begin
        cmp++; if (mem_a !== 32'h400 + 32'(c - 1)) begin err++; $display("FAIL flush_fetch_addr c%0d got %h", c, mem_a); end
      end
      if (c == 4) begin
        cmp++; if (mem_a !== 32'h0) begin err++; $display("FAIL flush_idle_addr got %h want 0", mem_a); end
      end
      if (c == 5) begin
        cmp++; if (mem_a !== 32'h500) begin err++; $display("FAIL flush_ls_addr got %h want 00000500", mem_a); end
      end
      cmp++; if (ls_done !== (c == 7)) begin err++; $display("FAIL flush_ls_done c%0d got %b want %b", c, ls_done, c == 7); end
      if (c == 7) begin
        cmp++; if (ls_rdata !== {24'd0, ref_rd(32'h500)}) begin
          err++; $display("FAIL flush_ls_rdata got %h want %h", ls_rdata, {24'd0, ref_rd(32'h500)});
        end
        ls_req = 1'b0;
      end
    end
  endtask

  task automatic test_rdy_pause;
    logic [31:0] ea [1:7];
    logic        ew [1:7];
    ea = '{32'h2000, 32'h2001, 32'h2001, 32'h2001, 32'h2001, 32'h2002, 32'h2003};
    ew = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tick;
    wlog.delete();
    ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h2000; ls_wdata = 32'hA1B2C3D4; ls_req = 1'b1;
    for (int i = 0; i < 4; i++) ref_mem[32'h2000 + 32'(i)] = ls_wdata[8*i +: 8];
    for (int c = 1; c <= 9; c++) begin
      tick;
      rdy_in = !(c >= 2 && c <= 4);
      #1;
      if (c <= 7) begin
        cmp++; if (mem_a !== ea[c]) begin err++; $display("FAIL pause_addr c%0d got %h want %h", c, mem_a, ea[c]); end
        cmp++; if (mem_wr !== ew[c]) begin err++; $display("FAIL pause_wr c%0d got %b want %b", c, mem_wr, ew[c]); end
      end
      cmp++; if (ls_done !== (c == 8)) begin err++; $display("FAIL pause_done c%0d got %b want %b", c, ls_done, c == 8); end
      if (c == 8) ls_req = 1'b0;
    end
    cmp++; if (wlog.size() != 4) begin err++; $display("FAIL pause_write_count got %0d want 4", wlog.size()); end
    ls_we = 1'b0;
  endtask

  task automatic test_reset_mid_read;
    tick;
    if_addr = 32'h100; if_req = 1'b1;
    tick; tick; #1;
    cmp++; if (mem_a !== 32'h101) begin err++; $display("FAIL rst_pre_addr got %h want 00000101", mem_a); end
    rst_in = 1'b1;
    #1;
    cmp++; if (mem_a !== 32'd0 || mem_wr !== 1'b0 || mem_dout !== 8'd0) begin
      err++; $display("FAIL rst_mid_bus mem_a=%h mem_wr=%b mem_dout=%h want zeros", mem_a, mem_wr, mem_dout);
    end
    cmp++; if (if_done !== 1'b0 || ls_done !== 1'b0) begin
      err++; $display("FAIL rst_mid_done if_done=%b ls_done=%b want 0/0", if_done, ls_done);
    end
    cmp++; if (if_data !== 32'd0 || ls_rdata !== 32'd0) begin
      err++; $display("FAIL rst_mid_data if_data=%h ls_rdata=%h want 0/0", if_data, ls_rdata);
    end
    if_req = 1'b0;
    tick;
    rst_in = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick; #1;
      cmp++; if (if_done !== 1'b0 || mem_a !== 32'd0) begin
        err++; $display("FAIL rst_lost_txn c%0d if_done=%b mem_a=%h want 0/0", c, if_done, mem_a);
      end
    end
  endtask

  task automatic test_random;
    bit          use_ls, we, exact, got, d;
    logic [1:0]  sz;
    logic [31:0] a, wd, exp_d;
    int          nb, cyc, lat;
    for (int t = 0; t < 60; t++) begin
      use_ls = 1'($urandom_range(0, 1));
      we     = use_ls && ($urandom_range(0, 1) == 1);
      sz     = 2'($urandom_range(0, 3));
      nb     = !use_ls ? 4 : (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      a      = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFE;
      if ($urandom_range(0, 3) == 0) a[17:16] = 2'b11;
      wd     = $urandom;
      exact  = (t < 20);
      exp_d  = exp_read(a, nb);
      if (we) for (int i = 0; i < nb; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
      tick;
      wlog.delete();
      rdy_in         = exact ? 1'b1 : ($urandom_range(0, 3) != 0);
      io_buffer_full = exact ? 1'b0 : ($urandom_range(0, 2) == 0);
      if (use_ls) begin
        ls_addr = a; ls_size = sz; ls_we = we; ls_wdata = wd; ls_req = 1'b1;
      end else begin
        if_addr = a; if_req = 1'b1;
      end
      got = 1'b0; cyc = 0; lat = 0;
      while (!got && cyc < 200) begin
        tick;
        cyc++;
        if (!exact) begin
          rdy_in         = ($urandom_range(0, 3) != 0);
          io_buffer_full = ($urandom_range(0, 2) == 0);
        end
        #1;
        d = use_ls ? ls_done : if_done;
        if (d) begin
          got = 1'b1; lat = cyc;
          ls_req = 1'b0; if_req = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
        end
      end
      cmp++; if (!got) begin err++; $display("FAIL rnd_timeout t%0d no done within 200 cycles", t); end
      if (got && exact) begin
        cmp++; if (lat != (we ? nb + 1 : nb + 2)) begin
          err++; $display("FAIL rnd_latency t%0d got %0d want %0d", t, lat, we ? nb + 1 : nb + 2);
        end
      end
      if (got && !we) begin
        cmp++; if ((use_ls ? ls_rdata : if_data) !== exp_d) begin
          err++; $display("FAIL rnd_read t%0d addr %h got %h want %h", t, a, use_ls ? ls_rdata : if_data, exp_d);
        end
      end
      if (got && we) begin
        cmp++; if (wlog.size() != nb) begin
          err++; $display("FAIL rnd_wcount t%0d got %0d want %0d", t, wlog.size(), nb);
        end else begin
          for (int i = 0; i < nb; i++) begin
            cmp++; if (wlog[i] !== {a + 32'(i), wd[8*i +: 8]}) begin
              err++; $display("FAIL rnd_write t%0d byte%0d got %h want %h", t, i, wlog[i], {a + 32'(i), wd[8*i +: 8]});
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_word_fetch;
    test_priority;
    test_half_store;
    test_io_stall;
    test_flush;
    test_rdy_pause;
    test_reset_mid_read;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-bus memory controller sitting between the CPU core and the external 8-bit memory/UART port of the `cpu` top. It arbitrates between the instruction-fetch unit (IF) and the load/store unit (LS) and sequences each multi-byte access into single-byte bus cycles. It assembles read bytes little-endian and stalls UART writes while `io_buffer_full` is high. All core-side requests flow through this block; it is the only driver of `mem_a`, `mem_dout` and `mem_wr`.

## Interface
- `LS_PRIORITY`, default 1: when IF and LS both request in IDLE, 1 grants LS and 0 grants IF.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `rdy_in`  in  1  global enable; low freezes the block.
- `mem_din`  in  8  read data; valid the cycle after its address.
- `mem_dout`  out  8  write data.
- `mem_a`  out  32  byte address.
- `mem_wr`  out  1  1 = write.
- `io_buffer_full`  in  1  UART TX buffer full.
- `if_req`  in  1  fetch request, held until `if_done` or flush.
- `if_addr`  in  32  fetch address (word read).
- `if_done`  out  1  one-cycle pulse; `if_data` valid.
- `if_data`  out  32  fetched word.
- `flush`  in  1  abort any IF transaction in progress.
- `ls_req`  in  1  load/store request, held until `ls_done`.
- `ls_we`  in  1  1 = store.
- `ls_size`  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- `ls_addr`  in  32  byte address.
- `ls_wdata`  in  32  store data; the low `ls_size` bytes are used.
- `ls_done`  out  1  one-cycle pulse; `ls_rdata` valid for loads.
- `ls_rdata`  out  32  load data, zero-extended; sign extension is done in LS.

## Operation
- States: IDLE, READ, WRITE.
- IDLE:
  - Samples requests and grants per `LS_PRIORITY`.
  - Latches address, size (n = 1/2/4 bytes), direction and write data.
  - Clears the internal byte index k and the data accumulator.
- READ:
  - Drives `mem_a = addr + k` with `mem_wr = 0` for k = 0..n-1.
  - The byte returned on `mem_din` one cycle later goes into accumulator bits [8k+7:8k].
  - After the last byte is captured: returns to IDLE, pulses done, presents data.
- WRITE:
  - Drives `mem_a = addr + k`, `mem_dout = wdata[8k+7:8k]`, `mem_wr = 1` for k = 0..n-1, then pulses done.
- I/O stall:
  - Applies when the address satisfies `addr[17:16] == 2'b11`, the access is a write, and `io_buffer_full = 1`.
  - That cycle drives `mem_wr = 0` and k does not advance.
- Flush:
  - `flush` high during an IF read: returns to IDLE next cycle; no `if_done`; captured bytes are discarded.
  - `flush` in IDLE suppresses the IF grant that cycle.
  - LS transactions are never affected by flush.
- Done cycle:
  - The controller is in IDLE but masks the just-served requester's `req` for that cycle.
  - The requester must drop `req` or present a new request; `req` high on the following cycle is a new request.
  - The other requester may be granted in the done cycle.
- Address arithmetic is 32-bit, wrapping modulo 2^32; no alignment checks.
- While in IDLE, `mem_a`, `mem_dout` and `mem_wr` are 0.

## Timing
- Reset (asynchronous, any state): IDLE.
  - `mem_a`, `mem_dout`, `mem_wr`, `if_done`, `ls_done` = 0.
  - `if_data`, `ls_rdata` = 0.
  - Any transaction in progress is lost with no done pulse.
- All outputs are registered, except that `mem_wr` is additionally gated by `rdy_in`.
- Read of n bytes, request seen in IDLE at cycle 0:
  - Addresses appear on cycles 1..n; data is captured on cycles 2..n+1; done is high at cycle n+2.
  - Word fetch: done at cycle 6.
- Write of n bytes, no stall: writes on cycles 1..n; done at cycle n+1. Each stall cycle adds one cycle.
- `rdy_in` low:
  - All state, counters and outputs are held; `mem_wr` reads 0; no capture happens.
  - Memory holds `mem_din` across the pause.
  - Done pulses remain high until the next `rdy_in`-high cycle.

## Test plan
- Word fetch: memory[0x100..0x103] = 13 05 50 00; `if_req` at cycle 0 -> `mem_a` = 0x100..0x103 on cycles 1-4; `if_done` at cycle 6; `if_data = 0x00500513`.
- Simultaneous `if_req` (0x0) and `ls_req` byte load (0x200 = 0xFF) with `LS_PRIORITY = 1` -> `ls_done` at cycle 3 with `ls_rdata = 0x000000FF`; IF granted in that done cycle; `if_done` at cycle 9.
- Half store 0xBEEF to 0x1001 -> writes EF to 0x1001 and BE to 0x1002 on cycles 1-2; `ls_done` at cycle 3.
- Byte store 0x41 to 0x30000 with `io_buffer_full` high on cycles 1-3 -> single `mem_wr` on cycle 4; `ls_done` at cycle 5.
- `flush` at cycle 3 of a fetch -> no `if_done`; IDLE at cycle 4; a pending `ls_req` is granted at cycle 4.
- `rdy_in` low cycles 2-4 during a word store -> outputs frozen with `mem_wr = 0`; `ls_done` at cycle 8. Separately, `rst_in` mid-read -> all outputs 0 immediately.
